// File: rtl/id_stage_if.sv
// ID-stage bus: IF/ID inputs, writeback port, flush, IF stall controls and ID/EX outputs.
// The master modport is the id_stage side; slave is the surrounding pipeline.
interface id_stage_if;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_flush;
   logic        pc_write;
   logic        if_id_write;
   logic [31:0] id_ex_pc_plus4;
   logic [31:0] id_ex_rs1_data;
   logic [31:0] id_ex_rs2_data;
   logic [31:0] id_ex_imm;
   logic [4:0]  id_ex_rs1;
   logic [4:0]  id_ex_rs2;
   logic [4:0]  id_ex_rd;
   logic [2:0]  id_ex_funct3;
   logic        id_ex_funct7b5;
   logic        id_ex_reg_write;
   logic        id_ex_mem_read;
   logic        id_ex_mem_write;
   logic        id_ex_mem_to_reg;
   logic        id_ex_alu_src;
   logic        id_ex_branch;
   logic [1:0]  id_ex_alu_op;

   modport master (
      input  if_id_pc_plus4, if_id_instr, wb_reg_write, wb_rd, wb_data, ex_flush,
      output pc_write, if_id_write,
      output id_ex_pc_plus4, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
      output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct3, id_ex_funct7b5,
      output id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
      output id_ex_alu_src, id_ex_branch, id_ex_alu_op
   );

   modport slave (
      output if_id_pc_plus4, if_id_instr, wb_reg_write, wb_rd, wb_data, ex_flush,
      input  pc_write, if_id_write,
      input  id_ex_pc_plus4, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
      input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct3, id_ex_funct7b5,
      input  id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
      input  id_ex_alu_src, id_ex_branch, id_ex_alu_op
   );
endinterface

// File: rtl/id_stage.sv
// RV32 decode stage: register file, control decode, immediates, load-use stall, ID/EX register.
// Define ID_STAGE_WB_BYPASS_EN to forward a same-cycle writeback onto the register read ports.
module id_stage (
   input logic        clk,
   input logic        reset,
   id_stage_if.master bus
);
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic logic [31:0] imm_i(input logic [31:0] ins);
      return {{20{ins[31]}}, ins[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] ins);
      return {{20{ins[31]}}, ins[31:25], ins[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] ins);
      return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   endfunction

   logic [31:0] regs [32];

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] rs1_data, rs2_data;
   logic [31:0] imm_dec;
   ctrl_t       ctrl_dec;
   logic        hazard, bubble;

   logic [31:0] pc_plus4_p1, rs1_data_p1, rs2_data_p1, imm_p1;
   logic [4:0]  rs1_p1, rs2_p1, rd_p1;
   logic [2:0]  funct3_p1;
   logic        funct7b5_p1;
   ctrl_t       ctrl_p1;

   assign instr  = bus.if_id_instr;
   assign opcode = instr[6:0];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign rd     = instr[11:7];

   // Reset wins over writeback; x0 is never written.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (bus.wb_reg_write && bus.wb_rd != 5'd0) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   always_comb begin
      rs1_data = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
      rs2_data = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
`ifdef ID_STAGE_WB_BYPASS_EN
      if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == rs1) rs1_data = bus.wb_data;
      if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == rs2) rs2_data = bus.wb_data;
`endif
   end

   always_comb begin
      ctrl_dec = '0;
      imm_dec  = '0;
      case (opcode)
         OP_R: begin
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_op    = 2'b10;
         end
         OP_I: begin
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_src   = 1'b1;
            ctrl_dec.alu_op    = 2'b10;
            imm_dec            = imm_i(instr);
         end
         OP_LD: begin
            ctrl_dec.reg_write  = 1'b1;
            ctrl_dec.mem_read   = 1'b1;
            ctrl_dec.mem_to_reg = 1'b1;
            ctrl_dec.alu_src    = 1'b1;
            imm_dec             = imm_i(instr);
         end
         OP_ST: begin
            ctrl_dec.mem_write = 1'b1;
            ctrl_dec.alu_src   = 1'b1;
            imm_dec            = imm_s(instr);
         end
         OP_BR: begin
            ctrl_dec.branch = 1'b1;
            ctrl_dec.alu_op = 2'b01;
            imm_dec         = imm_b(instr);
         end
         default: ;
      endcase
   end

   // A load in EX whose destination feeds this instruction holds IF/ID one cycle.
   assign hazard = ctrl_p1.mem_read && (rd_p1 != 5'd0) && ((rd_p1 == rs1) || (rd_p1 == rs2));
   assign bubble = bus.ex_flush || hazard;

   assign bus.pc_write    = reset || bus.ex_flush || !hazard;
   assign bus.if_id_write = reset || bus.ex_flush || !hazard;

   // ---- ID -> EX boundary ----
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_plus4_p1 <= '0;
         rs1_data_p1 <= '0;
         rs2_data_p1 <= '0;
         imm_p1      <= '0;
         rs1_p1      <= '0;
         rs2_p1      <= '0;
         rd_p1       <= '0;
         funct3_p1   <= '0;
         funct7b5_p1 <= 1'b0;
         ctrl_p1     <= '0;
      end else begin
         pc_plus4_p1 <= bus.if_id_pc_plus4;
         rs1_data_p1 <= rs1_data;
         rs2_data_p1 <= rs2_data;
         imm_p1      <= imm_dec;
         rs1_p1      <= rs1;
         rs2_p1      <= rs2;
         rd_p1       <= rd;
         funct3_p1   <= instr[14:12];
         funct7b5_p1 <= instr[30];
         ctrl_p1     <= bubble ? '0 : ctrl_dec;
      end
   end

   assign bus.id_ex_pc_plus4   = pc_plus4_p1;
   assign bus.id_ex_rs1_data   = rs1_data_p1;
   assign bus.id_ex_rs2_data   = rs2_data_p1;
   assign bus.id_ex_imm        = imm_p1;
   assign bus.id_ex_rs1        = rs1_p1;
   assign bus.id_ex_rs2        = rs2_p1;
   assign bus.id_ex_rd         = rd_p1;
   assign bus.id_ex_funct3     = funct3_p1;
   assign bus.id_ex_funct7b5   = funct7b5_p1;
   assign bus.id_ex_reg_write  = ctrl_p1.reg_write;
   assign bus.id_ex_mem_read   = ctrl_p1.mem_read;
   assign bus.id_ex_mem_write  = ctrl_p1.mem_write;
   assign bus.id_ex_mem_to_reg = ctrl_p1.mem_to_reg;
   assign bus.id_ex_alu_src    = ctrl_p1.alu_src;
   assign bus.id_ex_branch     = ctrl_p1.branch;
   assign bus.id_ex_alu_op     = ctrl_p1.alu_op;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the ID/EX and stall outputs.
module tb_id_stage;
   localparam logic [7:0] C_NOP = 8'h00;
   localparam logic [7:0] C_R   = 8'h82;
   localparam logic [7:0] C_I   = 8'h8A;
   localparam logic [7:0] C_LD  = 8'hD8;
   localparam logic [7:0] C_ST  = 8'h28;
   localparam logic [7:0] C_BR  = 8'h05;

   localparam logic [31:0] NOP_I = 32'h00000013;
   localparam logic [31:0] ADD6  = 32'h00528333;
   localparam logic [31:0] LW1   = 32'h00012083;
   localparam logic [31:0] ADD3  = 32'h001081B3;
   localparam logic [31:0] BEQ   = 32'hFE208CE3;
   localparam logic [31:0] ADD9  = 32'h000004B3;
   localparam logic [31:0] ADD10 = 32'h00738533;
   localparam logic [31:0] SW    = 32'hFE532E23;
   localparam logic [31:0] BAD   = 32'hFFFFFFFF;
   localparam logic [31:0] LW4   = 32'h0000A203;
   localparam logic [31:0] LW5   = 32'h00022283;

`ifdef ID_STAGE_WB_BYPASS_EN
   localparam logic [31:0] BYP = 32'hDEADBEEF;
`else
   localparam logic [31:0] BYP = 32'h00000000;
`endif

   typedef struct {
      string        name;
      logic [7:0]   ctrl;
      logic         pcw;
      logic         chk;
      logic [127:0] dat;
      logic [18:0]  fld;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   id_stage_if bus();
   exp_t q[$];
   int n_vec = 0;
   int n_bad = 0;

   id_stage dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         cmp({e.name, ".ctrl"}, 128'({bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write,
             bus.id_ex_mem_to_reg, bus.id_ex_alu_src, bus.id_ex_branch, bus.id_ex_alu_op}), 128'(e.ctrl));
         cmp({e.name, ".pc_write"}, 128'(bus.pc_write), 128'(e.pcw));
         cmp({e.name, ".if_id_write"}, 128'(bus.if_id_write), 128'(e.pcw));
         if (e.chk) begin
            cmp({e.name, ".data"}, {bus.id_ex_pc_plus4, bus.id_ex_rs1_data, bus.id_ex_rs2_data,
                bus.id_ex_imm}, e.dat);
            cmp({e.name, ".fields"}, 128'({bus.id_ex_rs1, bus.id_ex_rs2, bus.id_ex_rd,
                bus.id_ex_funct3, bus.id_ex_funct7b5}), 128'(e.fld));
         end
      end
   end

   task automatic step(input string nm, input logic rst_i, input logic [31:0] ins, input logic [31:0] pc4,
                       input logic wen, input logic [4:0] wrd, input logic [31:0] wd, input logic fl,
                       input logic [7:0] ctrl, input logic pcw, input logic chk,
                       input logic [31:0] e_pc4, input logic [31:0] e_r1d, input logic [31:0] e_r2d,
                       input logic [31:0] e_imm, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                       input logic [4:0] e_rd, input logic [2:0] e_f3, input logic e_f7);
      exp_t e;
      reset              = rst_i;
      bus.if_id_instr    = ins;
      bus.if_id_pc_plus4 = pc4;
      bus.wb_reg_write   = wen;
      bus.wb_rd          = wrd;
      bus.wb_data        = wd;
      bus.ex_flush       = fl;
      e.name = nm;
      e.ctrl = ctrl;
      e.pcw  = pcw;
      e.chk  = chk;
      e.dat  = {e_pc4, e_r1d, e_r2d, e_imm};
      e.fld  = {e_rs1, e_rs2, e_rd, e_f3, e_f7};
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset              = 1'b1;
      bus.if_id_instr    = NOP_I;
      bus.if_id_pc_plus4 = 32'd0;
      bus.wb_reg_write   = 1'b0;
      bus.wb_rd          = 5'd0;
      bus.wb_data        = 32'd0;
      bus.ex_flush       = 1'b0;
      @(posedge clk);
      #1;
      //   name            rst ins    pc4 wen rd  wdata         fl ctrl   pcw chk e_pc4 e_r1d         e_r2d         e_imm         rs1 rs2 rd  f3 f7
      step("reset_state",  0, NOP_I,  4,  0, 0,  32'h0,        0, C_NOP, 1,  1,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("addi_dec",     0, NOP_I,  8,  1, 5,  32'h1234,     0, C_I,   1,  1,  4,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("addi_again",   0, ADD6,   12, 0, 0,  32'h0,        0, C_I,   1,  1,  8,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("add_x6",       0, LW1,    16, 0, 0,  32'h0,        0, C_R,   1,  1,  12,   32'h1234,     32'h1234,     32'h0,        5,  5,  6,  0, 0);
      step("lw_hazard",    0, ADD3,   20, 0, 0,  32'h0,        0, C_LD,  0,  1,  16,   32'h0,        32'h0,        32'h0,        2,  0,  1,  2, 0);
      step("stall_bubble", 0, ADD3,   20, 0, 0,  32'h0,        0, C_NOP, 1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("add_x3",       0, NOP_I,  24, 0, 0,  32'h0,        0, C_R,   1,  1,  20,   32'h0,        32'h0,        32'h0,        1,  1,  3,  0, 0);
      step("pre_flush",    0, LW1,    28, 0, 0,  32'h0,        0, C_I,   1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("flush_hazard", 0, ADD3,   32, 0, 0,  32'h0,        1, C_LD,  1,  1,  28,   32'h0,        32'h0,        32'h0,        2,  0,  1,  2, 0);
      step("flush_bubble", 0, NOP_I,  36, 0, 0,  32'h0,        0, C_NOP, 1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("wb_x0",        0, BEQ,    40, 1, 0,  32'h5,        0, C_I,   1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("beq",          0, ADD9,   44, 0, 0,  32'h0,        0, C_BR,  1,  1,  40,   32'h0,        32'h0,        32'hFFFFFFF8, 1,  2,  25, 0, 1);
      step("x0_read",      0, NOP_I,  48, 0, 0,  32'h0,        0, C_R,   1,  1,  44,   32'h0,        32'h0,        32'h0,        0,  0,  9,  0, 0);
      step("wb_x7",        0, ADD10,  52, 1, 7,  32'hDEADBEEF, 0, C_I,   1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("wb_same_cyc",  0, NOP_I,  56, 0, 0,  32'h0,        0, C_R,   1,  1,  52,   BYP,          BYP,          32'h0,        7,  7,  10, 0, 0);
      step("x7_reread",    0, ADD10,  60, 0, 0,  32'h0,        0, C_I,   1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("x7_stored",    0, NOP_I,  64, 0, 0,  32'h0,        0, C_R,   1,  1,  60,   32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        7,  7,  10, 0, 0);
      step("pre_sw",       0, SW,     68, 0, 0,  32'h0,        0, C_I,   1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("sw",           0, BAD,    72, 0, 0,  32'h0,        0, C_ST,  1,  1,  68,   32'h0,        32'h1234,     32'hFFFFFFFC, 6,  5,  28, 2, 1);
      step("bad_opcode",   0, NOP_I,  76, 0, 0,  32'h0,        0, C_NOP, 1,  1,  72,   32'h0,        32'h0,        32'h0,        31, 31, 31, 7, 1);
      step("pre_rst_lw",   0, LW1,    80, 0, 0,  32'h0,        0, C_I,   1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("rst_in_stall", 1, ADD3,   84, 1, 9,  32'h77,       0, C_LD,  1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("rst_clear",    0, ADD3,   84, 0, 0,  32'h0,        0, C_NOP, 1,  1,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("post_rst",     0, ADD10,  88, 0, 0,  32'h0,        0, C_R,   1,  1,  84,   32'h0,        32'h0,        32'h0,        1,  1,  3,  0, 0);
      step("rf_cleared",   0, NOP_I,  92, 0, 0,  32'h0,        0, C_R,   1,  1,  88,   32'h0,        32'h0,        32'h0,        7,  7,  10, 0, 0);
      step("chain_lw1",    0, LW1,    96, 0, 0,  32'h0,        0, C_I,   1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("chain_lw4",    0, LW4,    100,0, 0,  32'h0,        0, C_LD,  0,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("chain_bub1",   0, LW4,    100,0, 0,  32'h0,        0, C_NOP, 1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("chain_lw5",    0, LW5,    104,0, 0,  32'h0,        0, C_LD,  0,  1,  100,  32'h0,        32'h0,        32'h0,        1,  0,  4,  2, 0);
      step("chain_bub2",   0, LW5,    104,0, 0,  32'h0,        0, C_NOP, 1,  0,  0,    32'h0,        32'h0,        32'h0,        0,  0,  0,  0, 0);
      step("chain_issue",  0, NOP_I,  108,0, 0,  32'h0,        0, C_LD,  1,  1,  104,  32'h0,        32'h0,        32'h0,        4,  0,  5,  2, 0);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d pending expectations required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have: if_id_pc_plus4  in  32  PC+4 from IF/ID register; if_id_instr  in  32  instruction from IF/ID register.
REQ-003 SHALL have: wb_reg_write  in  1  writeback enable; wb_rd  in  5  writeback destination; wb_data  in  32  writeback value.
REQ-004 SHALL have: ex_flush  in  1  taken branch resolved in EX; squash the instruction currently in ID.
REQ-005 SHALL have: pc_write  out  1  PC update enable; if_id_write  out  1  IF/ID load enable (both to IF stage).
REQ-006 SHALL have ID/EX outputs: id_ex_pc_plus4 32, id_ex_rs1_data 32, id_ex_rs2_data 32, id_ex_imm 32, id_ex_rs1 5, id_ex_rs2 5, id_ex_rd 5, id_ex_funct3 3, id_ex_funct7b5 1.
REQ-007 SHALL have ID/EX control outputs, 1 bit unless noted: id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch, id_ex_alu_op (2 bits).

Function
REQ-008 Register file SHALL be 32x32; x0 reads 0; write at clk edge when wb_reg_write=1 and wb_rd!=0.
REQ-009 Decode by opcode -- R 0110011: reg_write, alu_op=10; I-ALU 0010011: reg_write, alu_src, alu_op=10; load 0000011: reg_write, mem_read, mem_to_reg, alu_src, alu_op=00; store 0100011: mem_write, alu_src, alu_op=00; branch 1100011: branch, alu_op=01.
REQ-010 Any other opcode SHALL decode as NOP: all control bits 0.
REQ-011 Immediate SHALL be sign-extended from bit 31: I-type instr[31:20]; S-type {instr[31:25],instr[11:7]}; B-type {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; R-type 0.
REQ-012 Load-use hazard = id_ex_mem_read & (id_ex_rd!=0) & (id_ex_rd==instr[19:15] | id_ex_rd==instr[24:20]).
REQ-013 pc_write and if_id_write SHALL be combinational: 0 during load-use hazard, else 1.
REQ-014 On hazard, next edge SHALL load bubble (all control bits 0) into ID/EX; data fields don't-care.
REQ-015 ex_flush=1 SHALL load bubble into ID/EX at next edge; flush has priority over hazard and forces pc_write=if_id_write=1.
REQ-016 Otherwise ID/EX SHALL capture decoded fields every edge; latency IF/ID -> ID/EX exactly 1 cycle.
REQ-017 rs1/rs2/rd/funct fields SHALL come from instr[19:15], [24:20], [11:7], [14:12], bit 30.
REQ-018 Stall SHALL last exactly one cycle per load-use pair; a second dependent load after the stall re-evaluates normally.

Reset
REQ-019 reset=1 at clk edge SHALL clear all ID/EX outputs to 0 and all 31 registers x1..x31 to 0.
REQ-020 During reset pc_write=if_id_write=1 (ID/EX mem_read=0 implies no hazard); reset mid-stall SHALL cancel the stall next cycle.
REQ-021 Reset SHALL take priority over writeback, flush and hazard.

Configuration
REQ-022 Macro ID_STAGE_WB_BYPASS_EN SHALL control register-file write-through.
REQ-023 Defined: read of register equal to wb_rd while wb_reg_write=1 and wb_rd!=0 returns wb_data in same cycle.
REQ-024 Undefined: same read returns previous stored value; write visible the following cycle.

Verification
REQ-025 Reset 1 cycle, instr=0x00000013 (addi x0,x0,0) -> all ID/EX 0 after reset, then reg_write=1, alu_src=1, rd=0, pc_write=1.
REQ-026 wb write x5=0x1234, then instr 0x00528333 (add x6,x5,x5) -> id_ex_rs1_data=id_ex_rs2_data=0x1234, rd=6, alu_op=10.
REQ-027 lw x1,0(x2) (0x00012083) then add x3,x1,x1 (0x001081B3) held -> pc_write=if_id_write=0 one cycle, bubble in ID/EX, then add issues with rd=3.
REQ-028 Same sequence with ex_flush=1 during hazard cycle -> pc_write=1, ID/EX bubble, no stall.
REQ-029 wb x7=0xDEADBEEF same cycle as decode of instr reading x7 -> 0xDEADBEEF with ID_STAGE_WB_BYPASS_EN, 0 without.
REQ-030 beq x1,x2,-8 (0xFE208CE3) -> id_ex_branch=1, imm=0xFFFFFFF8; wb to x0 value 5 -> later read of x0 returns 0.
